// File: rtl/serial_adder_if.sv
// Start/done handshake bundle for serial_adder: operands in, result and status out.
// SERIAL_ADDER_SUB_EN adds the sub request line alongside the operands.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;

    modport master (output start, a, b, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock through a half-adder pair and a carry flop.
// Define SERIAL_ADDER_SUB_EN to add a sub request that computes a - b.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    serial_adder_if.slave bus
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    count;
    logic             carry;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    // Two chained half adders form the full-adder bit slice.
    logic s0, c0, s, c_next;
    assign s0     = opa[0] ^ opb[0];
    assign c0     = opa[0] & opb[0];
    assign s      = s0 ^ carry;
    assign c_next = c0 | (s0 & carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            sum_q  <= '0;
            count  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        opa    <= bus.a;
`ifdef SERIAL_ADDER_SUB_EN
                        // Subtraction is a + ~b + 1, so invert B and seed the carry.
                        opb    <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub;
`else
                        opb    <= bus.b;
                        carry  <= 1'b0;
`endif
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    res   <= (res >> 1) | (WIDTH'(s) << (WIDTH - 1));
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= c_next;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    sum_q  <= res;
                    cout_q <= carry;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule
